// File: rtl/soc_reset_ctrl.sv
// rtl/soc_reset_ctrl.sv - soft-reset sequencer: source collection, interconnect drain, stretched reset pulse
// Sticky cause register survives the soft reset it produces; only sys_reset clears the block.
module soc_reset_ctrl #(
  parameter int WDT_WIDTH     = 24,
  parameter int DRAIN_TIMEOUT = 256,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset,
  input  logic                 sw_req,
  input  logic                 wdt_en,
  input  logic                 wdt_kick,
  input  logic [WDT_WIDTH-1:0] wdt_load,
  output logic                 quiesce_req,
  input  logic                 quiesce_ack,
  output logic                 soft_reset,
  output logic                 busy,
  output logic [2:0]           cause,
  input  logic                 cause_clr
);

  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

  state_t               state;
  logic [WDT_WIDTH-1:0] wdt_cnt;
  logic                 wdt_en_q;
  logic [DW-1:0]        drain_cnt;
  logic [HW-1:0]        hold_cnt;

  logic       sw_trig;
  logic       wdt_expire;
  logic       drain_timeout;
  logic       wdt_reload;
  logic [2:0] cause_set;

  // The first enabled cycle only loads the counter, so expiry needs wdt_en held for two cycles.
  always_comb begin
    sw_trig       = (state == IDLE) && sw_req;
    wdt_expire    = (state == IDLE) && wdt_en && wdt_en_q && !wdt_kick && (wdt_cnt == '0);
    drain_timeout = (state == DRAIN) && !quiesce_ack && (drain_cnt == DRAIN_LAST);
    wdt_reload    = !wdt_en || !wdt_en_q || wdt_kick || (state != IDLE);
    cause_set     = {drain_timeout, wdt_expire, sw_trig};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state       <= IDLE;
      quiesce_req <= 1'b0;
      soft_reset  <= 1'b0;
      busy        <= 1'b0;
      cause       <= 3'b000;
      wdt_cnt     <= wdt_load;
      wdt_en_q    <= 1'b0;
      drain_cnt   <= '0;
      hold_cnt    <= '0;
    end else begin
      wdt_en_q <= wdt_en;
      if (wdt_reload)
        wdt_cnt <= wdt_load;
      else if (wdt_cnt != '0)
        wdt_cnt <= wdt_cnt - WDT_WIDTH'(1);

      // New sources win over a same-cycle clear.
      cause <= (cause_clr ? 3'b000 : cause) | cause_set;

      case (state)
        IDLE: begin
          drain_cnt <= '0;
          hold_cnt  <= '0;
          if (sw_trig || wdt_expire) begin
            state       <= DRAIN;
            quiesce_req <= 1'b1;
            busy        <= 1'b1;
          end
        end
        DRAIN: begin
          if (quiesce_ack || drain_timeout) begin
            state      <= HOLD;
            soft_reset <= 1'b1;
            drain_cnt  <= '0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state       <= IDLE;
            soft_reset  <= 1'b0;
            quiesce_req <= 1'b0;
            busy        <= 1'b0;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          soft_reset  <= 1'b0;
          quiesce_req <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// tb/tb_soc_reset_ctrl.sv - randomized self-checking bench for soc_reset_ctrl
module tb_soc_reset_ctrl;
  localparam int WW = 24;
  localparam int DT = 8;
  localparam int HC = 16;

  logic          sys_clk = 1'b0;
  logic          sys_reset, sw_req, wdt_en, wdt_kick, quiesce_ack, cause_clr;
  logic [WW-1:0] wdt_load;
  logic          quiesce_req, soft_reset, busy;
  logic [2:0]    cause;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  soc_reset_ctrl #(.WDT_WIDTH(WW), .DRAIN_TIMEOUT(DT), .HOLD_CYCLES(HC)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .sw_req(sw_req), .wdt_en(wdt_en),
    .wdt_kick(wdt_kick), .wdt_load(wdt_load), .quiesce_req(quiesce_req),
    .quiesce_ack(quiesce_ack), .soft_reset(soft_reset), .busy(busy),
    .cause(cause), .cause_clr(cause_clr)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_reset = 1'b1; sw_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    quiesce_ack = 1'b0; cause_clr = 1'b0;
    tick();
    tick();
    sys_reset = 1'b0;
  endtask

  // Expected {cause, busy, quiesce_req, soft_reset} in cycle c for a software request
  // in cycle s with ack held high from cycle a (a < 0: never).
  function automatic logic [5:0] sw_model(int c, int s, int a);
    int ds, hs, first;
    bit to;
    logic q, r;
    logic [2:0] cz;
    ds    = s + 1;
    first = (a < 0) ? -1 : ((a > ds) ? a : ds);
    to    = (first < 0) || (first - ds >= DT);
    hs    = to ? ds + DT : first + 1;
    q     = (c >= ds) && (c < hs + HC);
    r     = (c >= hs) && (c < hs + HC);
    cz    = {to && (c >= hs), 1'b0, c >= ds};
    return {cz, q, q, r};
  endfunction

  task automatic test_reset();
    int n;
    do_reset();
    tests++;
    if ({quiesce_req, soft_reset, busy, cause} !== 6'b0) begin
      fails++;
      $display("FAIL reset_state: got qreq=%b srst=%b busy=%b cause=%b want all 0",
               quiesce_req, soft_reset, busy, cause);
    end
    sw_req = 1'b1; tick(); sw_req = 1'b0; quiesce_ack = 1'b1;
    n = 0;
    while (!soft_reset && n < 40) begin tick(); n++; end
    tests++;
    if (!soft_reset) begin
      fails++;
      $display("FAIL abort_reach_hold: got soft_reset=0 want 1 within 40 cycles");
    end
    repeat (4) tick();
    tests++;
    if (soft_reset !== 1'b1) begin
      fails++;
      $display("FAIL abort_hold5: got soft_reset=%b want 1", soft_reset);
    end
    sys_reset = 1'b1;
    tick();
    tests++;
    if ({quiesce_req, soft_reset, busy, cause} !== 6'b0) begin
      fails++;
      $display("FAIL abort_state: got qreq=%b srst=%b busy=%b cause=%b want all 0",
               quiesce_req, soft_reset, busy, cause);
    end
    sys_reset = 1'b0; quiesce_ack = 1'b0;
  endtask

  task automatic test_sw_scenario(input string name, input int s, input int a, input int ncyc);
    logic [5:0] exp;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      exp = sw_model(c, s, a);
      tests++;
      if ({cause, busy, quiesce_req, soft_reset} !== exp) begin
        fails++;
        $display("FAIL %s c=%0d: got cause=%b busy=%b qreq=%b srst=%b want %b",
                 name, c, cause, busy, quiesce_req, soft_reset, exp);
      end
      sw_req = (c == s);
      quiesce_ack = (a >= 0) && (c >= a);
      tick();
    end
    sw_req = 1'b0; quiesce_ack = 1'b0;
  endtask

  task automatic test_sw_prompt();
    test_sw_scenario("sw_prompt", 10, 13, 35);
  endtask

  task automatic test_timeout();
    test_sw_scenario("timeout_noack", 0, -1, 30);
    test_sw_scenario("timeout_ack_last", 0, DT, 30);
    test_sw_scenario("timeout_ack_late", 0, DT + 1, 30);
  endtask

  task automatic test_random();
    int s, a;
    for (int i = 0; i < 12; i++) begin
      s = $urandom_range(2, 6);
      a = ($urandom_range(0, 3) == 0) ? -1 : s - 2 + $urandom_range(0, DT + 3);
      test_sw_scenario("random_sw", s, a, s + DT + HC + 4);
    end
  endtask

  task automatic wdt_run(input int load);
    do_reset();
    wdt_load = WW'(load);
    for (int c = 0; c <= load + 5; c++) begin
      tests++;
      if (quiesce_req !== (c >= load + 2) || busy !== (c >= load + 2) ||
          cause !== ((c >= load + 2) ? 3'b010 : 3'b000)) begin
        fails++;
        $display("FAIL wdt_load%0d c=%0d: got qreq=%b busy=%b cause=%b want qreq=%b cause=%b",
                 load, c, quiesce_req, busy, cause, c >= load + 2,
                 (c >= load + 2) ? 3'b010 : 3'b000);
      end
      wdt_en = 1'b1;
      tick();
    end
    wdt_en = 1'b0;
  endtask

  task automatic test_watchdog();
    wdt_run(20);
    wdt_run(0);
    wdt_run(int'($urandom_range(1, 40)));
  endtask

  task automatic test_wdt_kick();
    int bad;
    do_reset();
    wdt_load = 24'd20;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (busy || quiesce_req) bad++;
      wdt_en = 1'b1;
      wdt_kick = (c % 10 == 9);
      tick();
    end
    wdt_kick = 1'b0;
    tests++;
    if (bad != 0 || cause !== 3'b000) begin
      fails++;
      $display("FAIL wdt_kick_periodic: got %0d busy cycles cause=%b want 0 and 000", bad, cause);
    end
    do_reset();
    wdt_load = 24'd5;
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (quiesce_req !== (c >= 13)) begin
        fails++;
        $display("FAIL wdt_kick_at_expiry c=%0d: got qreq=%b want %b", c, quiesce_req, c >= 13);
      end
      wdt_en = 1'b1;
      wdt_kick = (c == 6);
      tick();
    end
    wdt_en = 1'b0; wdt_kick = 1'b0;
  endtask

  task automatic test_simultaneous();
    int high, rises;
    logic prev;
    do_reset();
    wdt_load = 24'd4;
    high = 0; rises = 0; prev = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tests++;
      if (soft_reset !== (c >= 9 && c <= 24) || quiesce_req !== (c >= 6 && c <= 24)) begin
        fails++;
        $display("FAIL simul c=%0d: got srst=%b qreq=%b want %b %b",
                 c, soft_reset, quiesce_req, c >= 9 && c <= 24, c >= 6 && c <= 24);
      end
      if (soft_reset) high++;
      if (soft_reset && !prev) rises++;
      prev = soft_reset;
      wdt_en = (c <= 5);
      sw_req = (c == 5) || (c == 12);
      cause_clr = (c == 5);
      quiesce_ack = (c >= 8);
      tick();
    end
    sw_req = 1'b0; cause_clr = 1'b0; quiesce_ack = 1'b0;
    tests++;
    if (cause !== 3'b011 || high != HC || rises != 1) begin
      fails++;
      $display("FAIL simul_summary: got cause=%b high=%0d pulses=%0d want 011 %0d 1",
               cause, high, rises, HC);
    end
  endtask

  task automatic test_cause_clr();
    do_reset();
    wdt_load = 24'd0;
    for (int c = 0; c < 30; c++) begin
      wdt_en = (c <= 1);
      sw_req = (c == 1);
      tick();
    end
    sw_req = 1'b0; wdt_en = 1'b0;
    tests++;
    if (cause !== 3'b111 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cause_all_set: got cause=%b busy=%b want 111 0", cause, busy);
    end
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    tests++;
    if (cause !== 3'b000 || busy !== 1'b0 || quiesce_req !== 1'b0 || soft_reset !== 1'b0) begin
      fails++;
      $display("FAIL cause_clear: got cause=%b busy=%b qreq=%b srst=%b want 000 0 0 0",
               cause, busy, quiesce_req, soft_reset);
    end
    repeat (3) tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL cause_clear_idle: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    wdt_load = '0;
    test_reset();
    test_sw_prompt();
    test_timeout();
    test_random();
    test_watchdog();
    test_wdt_kick();
    test_simultaneous();
    test_cause_clr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
